img_flow_feeder: RTL and testbench
==================================

Name: img_flow_feeder

Overview:
- Downstream consumer of the image-flow ROM stage: drives its 22-bit `count` address and registers the 34-bit word returned.
- Splits each word into a 32-bit pixel payload (four 8-bit pixels), an init flag (bit 1) and an array reset flag (bit 0).
- Delivers payload words to the FSBM processing array over a valid/ready handshake, with backpressure stalling address advance.

Parameters:
- ADDR_W, 22, width of `count`.
- LAST_ADDR, 4194303, final address fetched in one pass.
- WORD_W, 34, input word width; payload is WORD_W-2 bits.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a pass at address 0
- count  output  ADDR_W  address to image-flow ROM
- data  input  WORD_W  ROM word for current `count`, valid in the same cycle
- pix_data  output  32  payload `data[33:2]`; pixel 0 = bits [7:0]
- pix_init  output  1  `data[1]` of the word in `pix_data`; marks first word of a new block
- pix_valid  output  1  `pix_data` / `pix_init` valid
- pix_ready  input  1  consumer accepts when `pix_valid` && `pix_ready` at clk edge
- array_rst_n  output  1  registered `data[0]` of last consumed word; active-low reset to array
- busy  output  1  high in RUN and DRAIN
- done  output  1  one-cycle pulse when pass completes

Behaviour:
- Reset (async, `rst_n`=0): state IDLE, `count`=0, `pix_data`=0, `pix_init`=0, `pix_valid`=0, `array_rst_n`=0, `busy`=0, `done`=0. Reset mid-pass discards everything. A new `start` is required after reset.
- States:
  - IDLE: `start` -> RUN, `count`<=0.
  - RUN: fetches words.
  - DRAIN: last word fetched, waiting for the output register to empty.
  - DONE: single cycle; `done`=1, then -> IDLE.
- `start` outside IDLE is ignored.
- Slot free = !`pix_valid` || `pix_ready`.
- RUN, each edge with slot free: the word `data` at the current `count` is consumed.
  - `array_rst_n` <= `data[0]`.
  - If `data[0]`=1 (pixel word): `pix_data` <= `data[33:2]`, `pix_init` <= `data[1]`, `pix_valid` <= 1.
  - If `data[0]`=0 (control-only word): no pixel emitted; `pix_valid` <= 0 unless a held word is still unaccepted (cannot occur, since slot free implies the held word is accepted or absent).
  - If `count`==LAST_ADDR: -> DRAIN, `count` holds. Otherwise `count` <= `count`+1.
- RUN, slot not free: `count`, output register and `array_rst_n` hold. `data` is re-sampled later; the ROM is static, so this is safe.
- DRAIN: when `pix_valid`=0, or accepted this edge -> DONE; `pix_valid` <= 0 on acceptance.
- Throughput: one word per clock with `pix_ready` held at 1.
- Latency: `start` at edge E -> `count`=0 after E -> word 0 on `pix_valid` after E+1.
- Stability: `pix_data` and `pix_init` must be stable while `pix_valid`=1 and `pix_ready`=0.
- `count` never exceeds LAST_ADDR and never wraps within a pass. LAST_ADDR=0 is legal: one word, then DRAIN.
- `array_rst_n` keeps its last value through IDLE/DONE; only reset forces it to 0.
- `busy`=1 exactly in RUN/DRAIN.

Optional Feature:
- Macro: `FEED_LOOP_EN`.
- Defined: in RUN at `count`==LAST_ADDR with slot free, `count` <= 0 and the FSM stays in RUN (continuous looping).
  - `done` pulses one cycle at each wrap instead of entering DRAIN/DONE.
  - A `start` pulse in RUN stops the loop after the current word: -> DRAIN.
- Undefined: single pass as above; `start` in RUN ignored.

Test Plan:
- Reset then `start`, ROM words 0..3 = {payload 0x11223344, bits 01}, {0xAABBCCDD, 11}, {0x0, 00}, {0x55667788, 01}, LAST_ADDR=3, `pix_ready`=1 -> three pixel beats 0x11223344 (init 0), 0xAABBCCDD (init 1), 0x55667788 (init 0). `array_rst_n` sequence 1, 1, 0, 1. `done` pulses once; `busy` high 5 cycles.
- Backpressure: `pix_ready`=0 for 4 cycles while `pix_valid`=1 -> `count` and `pix_data` frozen. Release -> no word lost or duplicated (compare against ROM scoreboard).
- Random `pix_ready` (50%) over LAST_ADDR=255 -> exactly the pixel words in address order; `done` once after the last acceptance.
- Assert `rst_n`=0 mid-pass at `count`=100 -> next cycle all outputs at reset values. New `start` restarts at `count`=0.
- `start` pulsed during RUN -> ignored, pass completes normally. LAST_ADDR=0 -> one beat, then `done`.
- `FEED_LOOP_EN`, LAST_ADDR=3 -> `count` 0,1,2,3,0,1..., `done` pulse at each wrap. `start` in RUN -> finishes in DRAIN, returns to IDLE.

Source files
------------

// File: rtl/img_flow_feeder.sv
// Image-flow ROM feeder: walks `count` over the ROM, splits each 34-bit word into
// pixel payload / init / array-reset flags, and hands pixel words out on valid/ready.
// Optional continuous looping over the ROM is enabled with FEED_LOOP_EN.
module img_flow_feeder #(
    parameter int ADDR_W    = 22,
    parameter int LAST_ADDR = 4194303,
    parameter int WORD_W    = 34
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] count,
    input  logic [WORD_W-1:0] data,
    output logic [WORD_W-3:0] pix_data,
    output logic              pix_init,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              array_rst_n,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(LAST_ADDR);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t state, state_n;
    logic   slot_free, at_last;
    logic   take, adv, clr_cnt, drop_valid, done_n;

`ifdef FEED_LOOP_EN
    logic   stop_q;
`endif

    assign slot_free = !pix_valid || pix_ready;
    assign at_last   = (count == LAST_C);
    assign busy      = (state == RUN) || (state == DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        take       = 1'b0;
        adv        = 1'b0;
        clr_cnt    = 1'b0;
        drop_valid = 1'b0;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    clr_cnt = 1'b1;
                end
            end
            RUN: begin
                if (slot_free) begin
                    take = 1'b1;
`ifdef FEED_LOOP_EN
                    // A stop request finishes the current word and drains.
                    if (start || stop_q) begin
                        state_n = DRAIN;
                    end else if (at_last) begin
                        clr_cnt = 1'b1;
                        done_n  = 1'b1;
                    end else begin
                        adv = 1'b1;
                    end
`else
                    if (at_last) state_n = DRAIN;
                    else         adv     = 1'b1;
`endif
                end
            end
            DRAIN: begin
                if (slot_free) begin
                    drop_valid = 1'b1;
                    done_n     = 1'b1;
                    state_n    = FIN;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            pix_data    <= '0;
            pix_init    <= 1'b0;
            pix_valid   <= 1'b0;
            array_rst_n <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= done_n;
            if (clr_cnt)  count <= '0;
            else if (adv) count <= count + 1'b1;
            // Control-only words (bit 0 clear) update array reset but emit no pixel.
            if (take) begin
                array_rst_n <= data[0];
                pix_valid   <= data[0];
                if (data[0]) begin
                    pix_data <= data[WORD_W-1:2];
                    pix_init <= data[1];
                end
            end else if (drop_valid) begin
                pix_valid <= 1'b0;
            end
        end
    end

`ifdef FEED_LOOP_EN
    // Remembers a stop request that arrived while the output slot was blocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stop_q <= 1'b0;
        else        stop_q <= (state == RUN) && !slot_free && (start || stop_q);
    end
`endif

endmodule

// File: tb/tb_img_flow_feeder.sv
// Directed bench for img_flow_feeder: three instances (LAST_ADDR 3, 255, 0) fed by
// bench-side ROM tables; outputs are checked against hand-computed values and a scoreboard.
module tb_img_flow_feeder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // LAST_ADDR = 3 instance
    logic        st3, rdy3, v3, init3, arst3, busy3, done3;
    logic [21:0] c3;
    logic [33:0] dat3;
    logic [31:0] d3;
    // LAST_ADDR = 255 instance
    logic        st255, rdy255, v255, init255, arst255, busy255, done255;
    logic [21:0] c255;
    logic [33:0] dat255;
    logic [31:0] d255;
    // LAST_ADDR = 0 instance
    logic        st0, rdy0, v0, init0, arst0, busy0, done0;
    logic [21:0] c0;
    logic [33:0] dat0;
    logic [31:0] d0;

    img_flow_feeder #(.ADDR_W(22), .LAST_ADDR(3), .WORD_W(34)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(st3), .count(c3), .data(dat3),
        .pix_data(d3), .pix_init(init3), .pix_valid(v3), .pix_ready(rdy3),
        .array_rst_n(arst3), .busy(busy3), .done(done3));

    img_flow_feeder #(.ADDR_W(22), .LAST_ADDR(255), .WORD_W(34)) u_dut255 (
        .clk(clk), .rst_n(rst_n), .start(st255), .count(c255), .data(dat255),
        .pix_data(d255), .pix_init(init255), .pix_valid(v255), .pix_ready(rdy255),
        .array_rst_n(arst255), .busy(busy255), .done(done255));

    img_flow_feeder #(.ADDR_W(22), .LAST_ADDR(0), .WORD_W(34)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(st0), .count(c0), .data(dat0),
        .pix_data(d0), .pix_init(init0), .pix_valid(v0), .pix_ready(rdy0),
        .array_rst_n(arst0), .busy(busy0), .done(done0));

    function automatic logic [33:0] rom3(input logic [21:0] a);
        case (a[1:0])
            2'd0:    rom3 = {32'h11223344, 2'b01};
            2'd1:    rom3 = {32'hAABBCCDD, 2'b11};
            2'd2:    rom3 = {32'h00000000, 2'b00};
            default: rom3 = {32'h55667788, 2'b01};
        endcase
    endfunction

    function automatic logic [33:0] rom255(input logic [21:0] a);
        logic [7:0] b;
        b = a[7:0];
        rom255 = {b, ~b, b ^ 8'h5A, 8'hC3, (b[2:0] == 3'd0), (a % 3 != 1)};
    endfunction

    assign dat3   = rom3(c3);
    assign dat255 = rom255(c255);
    assign dat0   = {32'hDEADBEEF, 2'b11};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboards and cycle counters sample pre-edge values at each rising edge.
    logic [31:0] q3[$];
    logic [31:0] q255[$];
    int nbusy3, ndone3, ndone255, stab_err;
    logic        hold255;
    logic [31:0] hold_d255;
    logic        hold_i255;

    always @(posedge clk) begin
        if (rst_n) begin
            if (v3 && rdy3)     q3.push_back(d3);
            if (v255 && rdy255) q255.push_back(d255);
            if (busy3)   nbusy3++;
            if (done3)   ndone3++;
            if (done255) ndone255++;
            if (hold255 && (d255 !== hold_d255 || init255 !== hold_i255)) stab_err++;
            hold255   <= v255 && !rdy255;
            hold_d255 <= d255;
            hold_i255 <= init255;
        end else begin
            hold255 <= 1'b0;
        end
    end

    logic [31:0] exp3[3];
    logic [31:0] exp255[$];

    initial begin
        exp3[0] = 32'h11223344; exp3[1] = 32'hAABBCCDD; exp3[2] = 32'h55667788;
        for (int a = 0; a < 256; a++) begin
            logic [33:0] w;
            w = rom255(22'(a));
            if (w[0]) exp255.push_back(w[33:2]);
        end
        rst_n = 1'b0; st3 = 0; st255 = 0; st0 = 0; rdy3 = 0; rdy255 = 0; rdy0 = 1;
        #3;
        chk("rst_count", c3, 0);
        chk("rst_pix_data", d3, 0);
        chk("rst_pix_valid", v3, 0);
        chk("rst_array_rst_n", arst3, 0);
        chk("rst_busy", busy3, 0);
        chk("rst_done", done3, 0);
        tick; rst_n = 1'b1; tick;

`ifndef FEED_LOOP_EN
        // Basic pass, ready held high
        nbusy3 = 0; ndone3 = 0; rdy3 = 1;
        st3 = 1; tick; st3 = 0;
        chk("p1_count0", c3, 0);
        chk("p1_busy", busy3, 1);
        chk("p1_valid0", v3, 0);
        tick;
        chk("p1_w0_data", d3, 32'h11223344); chk("p1_w0_init", init3, 0);
        chk("p1_w0_valid", v3, 1); chk("p1_w0_arst", arst3, 1); chk("p1_w0_count", c3, 1);
        tick;
        chk("p1_w1_data", d3, 32'hAABBCCDD); chk("p1_w1_init", init3, 1);
        chk("p1_w1_arst", arst3, 1); chk("p1_w1_count", c3, 2);
        tick;
        chk("p1_w2_valid", v3, 0); chk("p1_w2_arst", arst3, 0); chk("p1_w2_count", c3, 3);
        tick;
        chk("p1_w3_data", d3, 32'h55667788); chk("p1_w3_init", init3, 0);
        chk("p1_w3_valid", v3, 1); chk("p1_w3_arst", arst3, 1);
        chk("p1_w3_count", c3, 3); chk("p1_drain_busy", busy3, 1);
        tick;
        chk("p1_done", done3, 1); chk("p1_done_busy", busy3, 0); chk("p1_done_valid", v3, 0);
        tick;
        chk("p1_idle_done", done3, 0); chk("p1_idle_arst", arst3, 1);
        chk("p1_busy_cycles", nbusy3, 5); chk("p1_done_pulses", ndone3, 1);

        // Backpressure: hold ready low for 4 cycles with a word pending
        q3.delete(); ndone3 = 0; rdy3 = 0;
        st3 = 1; tick; st3 = 0;
        tick;
        chk("bp_valid", v3, 1);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("bp_count_frozen", c3, 1);
            chk("bp_data_frozen", d3, 32'h11223344);
        end
        rdy3 = 1;
        for (int i = 0; i < 20 && !done3; i++) tick;
        chk("bp_done_seen", done3, 1);
        tick;
        chk("bp_beats", q3.size(), 3);
        for (int i = 0; i < 3 && i < q3.size(); i++) chk("bp_beat", q3[i], exp3[i]);
        chk("bp_done_pulses", ndone3, 1);

        // start during RUN is ignored
        q3.delete(); ndone3 = 0;
        st3 = 1; tick; st3 = 0;
        tick; tick;
        st3 = 1; tick; st3 = 0;
        for (int i = 0; i < 20 && !done3; i++) tick;
        chk("ign_done_seen", done3, 1);
        tick; tick; tick;
        chk("ign_beats", q3.size(), 3);
        for (int i = 0; i < 3 && i < q3.size(); i++) chk("ign_beat", q3[i], exp3[i]);
        chk("ign_done_pulses", ndone3, 1);
        chk("ign_idle_busy", busy3, 0);

        // LAST_ADDR = 0: one beat then done
        st0 = 1; tick; st0 = 0;
        chk("a0_count", c0, 0); chk("a0_busy", busy0, 1);
        tick;
        chk("a0_valid", v0, 1); chk("a0_data", d0, 32'hDEADBEEF); chk("a0_init", init0, 1);
        tick;
        chk("a0_done", done0, 1); chk("a0_valid_clr", v0, 0); chk("a0_busy_clr", busy0, 0);

        // Random ready over 256 addresses
        q255.delete(); ndone255 = 0; stab_err = 0;
        st255 = 1; tick; st255 = 0;
        for (int i = 0; i < 3000 && !done255; i++) begin
            rdy255 = 1'($urandom_range(0, 1));
            tick;
        end
        chk("rnd_done_seen", done255, 1);
        chk("rnd_beats", q255.size(), exp255.size());
        for (int i = 0; i < exp255.size() && i < q255.size(); i++) chk("rnd_beat", q255[i], exp255[i]);
        for (int i = 0; i < 5; i++) tick;
        chk("rnd_done_pulses", ndone255, 1);
        chk("rnd_stability", stab_err, 0);
`else
        // Looping: count wraps with a done pulse each wrap
        rdy3 = 1;
        st3 = 1; tick; st3 = 0;
        for (int i = 0; i <= 8; i++) begin
            chk("loop_count", c3, 22'(i % 4));
            chk("loop_done", done3, (i > 0 && i % 4 == 0));
            if (i < 8) tick;
        end
        st3 = 1; tick; st3 = 0;
        chk("loop_stop_busy", busy3, 1); chk("loop_stop_count", c3, 0);
        tick;
        chk("loop_stop_done", done3, 1); chk("loop_stop_idle", busy3, 0);
        tick;
        chk("loop_idle_done", done3, 0); chk("loop_idle_busy", busy3, 0);
`endif

        // Reset mid-pass at count 100, then restart from 0
        rdy255 = 1;
        st255 = 1; tick; st255 = 0;
        for (int i = 0; i < 300 && c255 != 100; i++) tick;
        chk("mid_count100", c255, 100);
        rst_n = 1'b0;
        tick;
        chk("mid_rst_count", c255, 0); chk("mid_rst_valid", v255, 0);
        chk("mid_rst_data", d255, 0); chk("mid_rst_init", init255, 0);
        chk("mid_rst_arst", arst255, 0); chk("mid_rst_busy", busy255, 0);
        chk("mid_rst_done", done255, 0);
        rst_n = 1'b1;
        tick; tick;
        chk("mid_needs_start", busy255, 0);
        st255 = 1; tick; st255 = 0;
        chk("mid_restart_count", c255, 0); chk("mid_restart_busy", busy255, 1);
        tick;
        chk("mid_restart_adv", c255, 1);
        rst_n = 1'b0; tick; rst_n = 1'b1; tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
